// File: rtl/fft_pkg.sv
// Shared FFT definitions: sizes, sample type, streamer states and bin bit reversal.
package fft_pkg;

  localparam int unsigned D_WIDTH     = 64;
  localparam int unsigned LOG_2_WIDTH = 6;
  localparam int unsigned SAMPLE_W    = 16;

  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef enum logic {IDLE, STREAM} stream_state_t;

  function automatic logic [LOG_2_WIDTH-1:0] bitrev(input logic [LOG_2_WIDTH-1:0] k);
    logic [LOG_2_WIDTH-1:0] r;
    r = '0;
    for (int unsigned j = 0; j < LOG_2_WIDTH; j++) begin
      r[j] = k[LOG_2_WIDTH-1-j];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bitrev_idx.sv
// Combinational bit reversal of a bin index; bit j of rev is bit (W-1-j) of idx.
module fft_bitrev_idx #(
  parameter int unsigned W = 6
) (
  input  logic [W-1:0] idx,
  output logic [W-1:0] rev
);

  always_comb begin
    rev = '0;
    for (int unsigned j = 0; j < W; j++) begin
      rev[j] = idx[W-1-j];
    end
  end

endmodule

// File: rtl/fft_result_streamer.sv
// Snapshots a complete FFT frame on fft_done and streams its bins over valid/ready in natural order.
module fft_result_streamer
  import fft_pkg::*;
#(
  parameter int unsigned BIT_REVERSE = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fft_done,
  input  sample_t                frame_Re [D_WIDTH],
  input  sample_t                frame_Im [D_WIDTH],
  output logic                   busy,
  output logic                   m_valid,
  input  logic                   m_ready,
  output sample_t                m_Re,
  output sample_t                m_Im,
  output logic [LOG_2_WIDTH-1:0] m_index,
  output logic                   m_last,
  output logic                   overrun
);

  localparam logic [LOG_2_WIDTH-1:0] LAST_K = LOG_2_WIDTH'(D_WIDTH - 1);

  stream_state_t          state, state_nxt;
  logic [LOG_2_WIDTH-1:0] k, k_rev, rd_addr;
  logic                   at_last, handshake, capture, drop;
  sample_t                snap_re [D_WIDTH];
  sample_t                snap_im [D_WIDTH];

  // A new frame is only accepted in IDLE or on the final handshake; anything else is dropped.
  always_comb begin
    state_nxt = state;
    handshake = 1'b0;
    capture   = 1'b0;
    drop      = 1'b0;
    at_last   = (k == LAST_K);
    case (state)
      IDLE: begin
        if (fft_done) begin
          capture   = 1'b1;
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        handshake = m_ready;
        if (handshake && at_last) begin
          if (fft_done) capture = 1'b1;
          else          state_nxt = IDLE;
        end
        drop = fft_done && !capture;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      k       <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= drop;
      if (capture)        k <= '0;
      else if (handshake) k <= k + 1'b1;
    end
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      snap_re <= '{default: '0};
      snap_im <= '{default: '0};
    end else if (capture) begin
      snap_re <= frame_Re;
      snap_im <= frame_Im;
    end
  end

  fft_bitrev_idx #(.W(LOG_2_WIDTH)) u_bitrev (
    .idx (k),
    .rev (k_rev)
  );

  assign rd_addr = (BIT_REVERSE != 0) ? k_rev : k;

  always_comb begin
    busy    = (state == STREAM);
    m_valid = busy;
    m_index = k;
    m_last  = busy && at_last;
    m_Re    = busy ? snap_re[rd_addr] : '0;
    m_Im    = busy ? snap_im[rd_addr] : '0;
  end

endmodule

// File: tb/tb_fft_result_streamer.sv
// Directed bench for fft_result_streamer: ordering, backpressure, overrun, back-to-back and async reset.
module tb_fft_result_streamer;
  import fft_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   fft_done = 1'b0;
  logic                   m_ready = 1'b0;
  sample_t                frame_Re [D_WIDTH];
  sample_t                frame_Im [D_WIDTH];
  logic                   busy, m_valid, m_last, overrun;
  sample_t                m_Re, m_Im;
  logic [LOG_2_WIDTH-1:0] m_index;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  fft_result_streamer #(.BIT_REVERSE(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .fft_done (fft_done),
    .frame_Re (frame_Re),
    .frame_Im (frame_Im),
    .busy     (busy),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_Re     (m_Re),
    .m_Im     (m_Im),
    .m_index  (m_index),
    .m_last   (m_last),
    .overrun  (overrun)
  );

  function automatic logic [5:0] rev6(input logic [5:0] k);
    logic [5:0] r;
    for (int j = 0; j < 6; j++) r[j] = k[5-j];
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [15:0] re_base, input logic [15:0] im_base);
    for (int i = 0; i < 64; i++) begin
      frame_Re[i] = re_base + 16'(i);
      frame_Im[i] = im_base + 16'(i);
    end
  endtask

  task automatic beat(input string tag, input int k, input logic [15:0] re_base, input logic [15:0] im_base);
    check({tag, "_valid"}, 32'(m_valid), 32'd1);
    check({tag, "_index"}, 32'(m_index), 32'(k));
    check({tag, "_re"},    32'(m_Re),    32'(re_base + 16'(rev6(6'(k)))));
    check({tag, "_im"},    32'(m_Im),    32'(im_base + 16'(rev6(6'(k)))));
    check({tag, "_last"},  32'(m_last),  32'(k == 63));
  endtask

  task automatic start_frame();
    fft_done = 1'b1;
    @(posedge clk);
    fft_done = 1'b0;
  endtask

  initial begin
    int acc;
    int cyc;

    // 1: reset dominates fft_done/m_ready
    load(16'h0000, 16'h0100);
    fft_done = 1'b1;
    m_ready  = 1'b1;
    repeat (3) @(posedge clk);
    check("rst_valid",   32'(m_valid), 32'd0);
    check("rst_busy",    32'(busy),    32'd0);
    check("rst_re",      32'(m_Re),    32'd0);
    check("rst_im",      32'(m_Im),    32'd0);
    check("rst_index",   32'(m_index), 32'd0);
    check("rst_last",    32'(m_last),  32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    rst      = 1'b1;
    fft_done = 1'b0;
    @(posedge clk);
    check("rel_busy",  32'(busy),    32'd0);
    check("rel_valid", 32'(m_valid), 32'd0);

    // 2: full frame with m_ready held high
    start_frame();
    check("s2_b1_re_hand", 32'(m_Re), 32'h0000);
    for (int k = 0; k < 64; k++) begin
      beat("s2", k, 16'h0000, 16'h0100);
      if (k == 1)  check("s2_k1_is_32",  32'(m_Re), 32'd32);
      if (k == 2)  check("s2_k2_is_16",  32'(m_Re), 32'd16);
      if (k == 63) check("s2_k63_is_63", 32'(m_Re), 32'd63);
      @(posedge clk);
    end
    check("s2_end_busy",  32'(busy),    32'd0);
    check("s2_end_valid", 32'(m_valid), 32'd0);

    // 3: random backpressure, ~30% ready
    m_ready = 1'b0;
    start_frame();
    acc = 0;
    cyc = 0;
    while (acc < 64 && cyc < 2000) begin
      beat("s3", acc, 16'h0000, 16'h0100);
      m_ready = ($urandom_range(0, 9) < 3);
      if (m_ready) acc++;
      cyc++;
      @(posedge clk);
    end
    m_ready = 1'b1;
    check("s3_accepts", 32'(acc),  32'd64);
    check("s3_end_busy", 32'(busy), 32'd0);

    // 4: overrun at beat 10
    load(16'h0000, 16'h0100);
    start_frame();
    for (int k = 0; k < 64; k++) begin
      beat("s4", k, 16'h0000, 16'h0100);
      check("s4_overrun", 32'(overrun), 32'(k == 11));
      if (k == 10) begin
        for (int i = 0; i < 64; i++) frame_Re[i] = 16'hFFFF;
        fft_done = 1'b1;
      end else begin
        fft_done = 1'b0;
      end
      @(posedge clk);
    end
    check("s4_end_busy",    32'(busy),    32'd0);
    check("s4_end_overrun", 32'(overrun), 32'd0);

    // 5: new frame coincident with the final handshake
    load(16'h0000, 16'h0100);
    start_frame();
    for (int k = 0; k < 63; k++) begin
      beat("s5a", k, 16'h0000, 16'h0100);
      @(posedge clk);
    end
    beat("s5a", 63, 16'h0000, 16'h0100);
    load(16'h2000, 16'h3000);
    start_frame();
    check("s5_overrun", 32'(overrun), 32'd0);
    check("s5_busy",    32'(busy),    32'd1);
    check("s5_b0_re",   32'(m_Re),    32'h2000);
    for (int k = 0; k < 64; k++) begin
      beat("s5b", k, 16'h2000, 16'h3000);
      @(posedge clk);
    end
    check("s5_end_busy", 32'(busy), 32'd0);

    // 6: async reset at beat 20
    load(16'h0000, 16'h0100);
    start_frame();
    for (int k = 0; k < 20; k++) begin
      beat("s6a", k, 16'h0000, 16'h0100);
      @(posedge clk);
    end
    beat("s6a", 20, 16'h0000, 16'h0100);
    #2 rst = 1'b0;
    #1;
    check("s6_async_valid", 32'(m_valid), 32'd0);
    check("s6_async_busy",  32'(busy),    32'd0);
    check("s6_async_index", 32'(m_index), 32'd0);
    check("s6_async_re",    32'(m_Re),    32'd0);
    @(posedge clk);
    rst = 1'b1;
    @(posedge clk);
    check("s6_rel_busy",  32'(busy),    32'd0);
    check("s6_rel_valid", 32'(m_valid), 32'd0);
    start_frame();
    for (int k = 0; k < 64; k++) begin
      beat("s6b", k, 16'h0000, 16'h0100);
      @(posedge clk);
    end
    check("s6_end_busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
